// File: rtl/md_pkg.sv
// Shared MD op, start and result-select encodings for the decoder, the issue
// controller and the HI/LO mul/div unit.
package md_pkg;

  localparam logic [3:0] MD_OP_NONE  = 4'd0;
  localparam logic [3:0] MD_OP_MULT  = 4'd1;
  localparam logic [3:0] MD_OP_MULTU = 4'd2;
  localparam logic [3:0] MD_OP_DIV   = 4'd3;
  localparam logic [3:0] MD_OP_DIVU  = 4'd4;
  localparam logic [3:0] MD_OP_MTHI  = 4'd5;
  localparam logic [3:0] MD_OP_MTLO  = 4'd6;
  localparam logic [3:0] MD_OP_MFHI  = 4'd7;
  localparam logic [3:0] MD_OP_MFLO  = 4'd8;

  localparam logic [2:0] MD_START_IDLE  = 3'd0;
  localparam logic [2:0] MD_START_MULT  = 3'd1;
  localparam logic [2:0] MD_START_MULTU = 3'd2;
  localparam logic [2:0] MD_START_DIV   = 3'd3;
  localparam logic [2:0] MD_START_DIVU  = 3'd4;
  localparam logic [2:0] MD_START_MTHI  = 3'd5;
  localparam logic [2:0] MD_START_MTLO  = 3'd6;

  localparam logic [1:0] RD_SEL_ALU = 2'd0;
  localparam logic [1:0] RD_SEL_HI  = 2'd1;
  localparam logic [1:0] RD_SEL_LO  = 2'd2;

  // Codes 9-15 are not MD ops and fall outside both classes.
  function automatic logic is_md_class(input logic [3:0] op);
    return (op >= MD_OP_MULT) && (op <= MD_OP_MFLO);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= MD_OP_MULT) && (op <= MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Local countdown that shadows the mul/div unit's busy window, loaded on a
// mult/div start code.
module md_lat_cnt
  import md_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] start,
  output logic       busy_sh
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((start == MD_START_MULT) || (start == MD_START_MULTU))
      cnt_d = CNT_W'(MUL_LAT);
    else if ((start == MD_START_DIV) || (start == MD_START_DIVU))
      cnt_d = CNT_W'(DIV_LAT);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign busy_sh = (cnt_q != '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue/stall controller in front of the HI/LO mul/div unit: registers
// the D-stage MD op, drives the start code and stalls D while the unit is busy.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        d_md_op,
  input  logic              ext_stall,
  input  logic              req,
  input  logic              md_busy,
  output logic [2:0]        md_start,
  output logic              md_stall,
  output logic [1:0]        e_rd_sel,
  output logic              busy_sh,
  output logic              busy_err,
  output logic [STAT_W-1:0] stall_cnt
);

  logic [3:0]        e_op_q, e_op_d;
  logic              busy_err_q, busy_err_d;
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  md_lat_cnt #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .busy_sh(busy_sh)
  );

  // Stall uses the req-gated start so a killed mult/div never holds up D.
  always_comb begin
    md_start = MD_START_IDLE;
    if (!req && (e_op_q >= MD_OP_MULT) && (e_op_q <= MD_OP_MTLO))
      md_start = e_op_q[2:0];

    e_rd_sel = RD_SEL_ALU;
    if (e_op_q == MD_OP_MFHI)      e_rd_sel = RD_SEL_HI;
    else if (e_op_q == MD_OP_MFLO) e_rd_sel = RD_SEL_LO;

    md_stall = is_md_class(d_md_op) && (busy_sh || is_muldiv({1'b0, md_start}));

    e_op_d = MD_OP_NONE;
    if (!(req || md_stall || ext_stall) && is_md_class(d_md_op))
      e_op_d = d_md_op;

    busy_err_d  = busy_err_q | (busy_sh ^ md_busy);
    stall_cnt_d = stall_cnt_q + STAT_W'(md_stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_op_q      <= MD_OP_NONE;
      busy_err_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      e_op_q      <= e_op_d;
      busy_err_q  <= busy_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_err  = busy_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: a per-cycle vector table plus hand-written
// sequences for the long-latency, kill, reset and busy cross-check cases.
module tb_md_issue_ctrl;

  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        d_md_op = 4'd0;
  logic              ext_stall = 1'b0;
  logic              req = 1'b0;
  logic              md_busy;
  logic [2:0]        md_start;
  logic              md_stall;
  logic [1:0]        e_rd_sel;
  logic              busy_sh;
  logic              busy_err;
  logic [STAT_W-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural mul/div unit busy, optionally forced low to provoke busy_err.
  logic [3:0] ucnt = 4'd0;
  logic       force_low = 1'b0;

  always @(posedge clk) begin
    if (rst)                                  ucnt <= 4'd0;
    else if (md_start == 3'd1 || md_start == 3'd2) ucnt <= 4'd5;
    else if (md_start == 3'd3 || md_start == 3'd4) ucnt <= 4'd10;
    else if (ucnt != 4'd0)                    ucnt <= ucnt - 4'd1;
  end
  assign md_busy = (ucnt != 4'd0) && !force_low;

  always #5 clk = ~clk;

  md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .STAT_W(STAT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .d_md_op  (d_md_op),
    .ext_stall(ext_stall),
    .req      (req),
    .md_busy  (md_busy),
    .md_start (md_start),
    .md_stall (md_stall),
    .e_rd_sel (e_rd_sel),
    .busy_sh  (busy_sh),
    .busy_err (busy_err),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [3:0] d;
    logic       ext;
    logic       rq;
    logic [2:0] st;
    logic       stl;
    logic [1:0] rd;
    logic       bsy;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // New inputs just after the edge; callers check mid-cycle.
  task automatic drive(input logic [3:0] d, input logic ext, input logic rq);
    @(posedge clk);
    #1;
    d_md_op   = d;
    ext_stall = ext;
    req       = rq;
    #4;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; d_md_op = 4'd0; ext_stall = 1'b0; req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #4;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int ns, nb;
    logic [3:0] exp_cnt[3];
    logic       exp_stl[3];

    //            d     ext   rq    st    stl   rd    bsy
    tbl[0]  = '{4'd1, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'd8, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{4'd8, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1};
    tbl[3]  = '{4'd8, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1};
    tbl[4]  = '{4'd8, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1};
    tbl[5]  = '{4'd8, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1};
    tbl[6]  = '{4'd8, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1};
    tbl[7]  = '{4'd8, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd2, 1'b0};
    tbl[9]  = '{4'd5, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
    tbl[10] = '{4'd7, 1'b0, 1'b0, 3'd5, 1'b0, 2'd0, 1'b0};
    tbl[11] = '{4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd1, 1'b0};
    tbl[12] = '{4'd3, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
    tbl[13] = '{4'd6, 1'b0, 1'b1, 3'd0, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
    tbl[15] = '{4'd1, 1'b1, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
    tbl[16] = '{4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{4'd9, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};
    tbl[18] = '{4'd0, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0};

    // Reset state
    do_reset();
    chk("rst.md_start", 32'(md_start), 0);
    chk("rst.md_stall", 32'(md_stall), 0);
    chk("rst.e_rd_sel", 32'(e_rd_sel), 0);
    chk("rst.busy_sh", 32'(busy_sh), 0);
    chk("rst.busy_err", 32'(busy_err), 0);
    chk("rst.stall_cnt", 32'(stall_cnt), 0);

    // Table: mult/mflo, mthi/mfhi, killed div, ext_stall bubble, op 9
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].d, tbl[i].ext, tbl[i].rq);
      chk($sformatf("tbl[%0d].md_start", i), 32'(md_start), 32'(tbl[i].st));
      chk($sformatf("tbl[%0d].md_stall", i), 32'(md_stall), 32'(tbl[i].stl));
      chk($sformatf("tbl[%0d].e_rd_sel", i), 32'(e_rd_sel), 32'(tbl[i].rd));
      chk($sformatf("tbl[%0d].busy_sh", i), 32'(busy_sh), 32'(tbl[i].bsy));
    end
    chk("tbl.stall_cnt", 32'(stall_cnt), 6);
    chk("tbl.busy_err", 32'(busy_err), 0);

    // divu then mfhi: 10 busy cycles, 11 stall cycles
    do_reset();
    drive(4'd4, 1'b0, 1'b0);
    drive(4'd7, 1'b0, 1'b0);
    chk("divu.md_start", 32'(md_start), 4);
    ns = 0; nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (md_stall) ns++;
      if (busy_sh) nb++;
      if (!md_stall) break;
      drive(4'd7, 1'b0, 1'b0);
    end
    chk("divu.stall_cycles", 32'(ns), 11);
    chk("divu.busy_cycles", 32'(nb), 10);
    drive(4'd0, 1'b0, 1'b0);
    chk("divu.e_rd_sel", 32'(e_rd_sel), 1);
    chk("divu.stall_cnt", 32'(stall_cnt), 11);

    // Six more stall cycles wrap the 4-bit counter: 17 mod 16
    drive(4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(4'd8, 1'b0, 1'b0);
    drive(4'd8, 1'b0, 1'b0);
    chk("wrap.md_stall", 32'(md_stall), 0);
    chk("wrap.stall_cnt", 32'(stall_cnt), 1);
    chk("wrap.busy_err", 32'(busy_err), 0);

    // mult, req at cnt=3: countdown continues, mflo stalls until cnt=0
    do_reset();
    drive(4'd1, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    chk("req.md_start", 32'(md_start), 1);
    chk("req.nonmd_nostall0", 32'(md_stall), 0);
    drive(4'd0, 1'b0, 1'b0);
    chk("req.nonmd_nostall1", 32'(md_stall), 0);
    chk("req.busy_sh", 32'(busy_sh), 1);
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd8, 1'b0, 1'b1);
    chk("req.cnt3", 32'(dut.u_cnt.cnt_q), 3);
    chk("req.stall3", 32'(md_stall), 1);
    exp_cnt = '{4'd2, 4'd1, 4'd0};
    exp_stl = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(4'd8, 1'b0, 1'b0);
      chk($sformatf("req.cnt[%0d]", i), 32'(dut.u_cnt.cnt_q), 32'(exp_cnt[i]));
      chk($sformatf("req.stall[%0d]", i), 32'(md_stall), 32'(exp_stl[i]));
    end
    drive(4'd0, 1'b0, 1'b0);
    chk("req.e_rd_sel", 32'(e_rd_sel), 2);

    // rst at cnt=7 during div
    do_reset();
    drive(4'd3, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    chk("rstmid.md_start", 32'(md_start), 3);
    for (int i = 0; i < 4; i++) drive(4'd8, 1'b0, 1'b0);
    chk("rstmid.cnt7", 32'(dut.u_cnt.cnt_q), 7);
    rst = 1'b1;
    drive(4'd8, 1'b0, 1'b0);
    chk("rstmid.cnt0", 32'(dut.u_cnt.cnt_q), 0);
    chk("rstmid.md_stall", 32'(md_stall), 0);
    chk("rstmid.stall_cnt", 32'(stall_cnt), 0);
    chk("rstmid.busy_sh", 32'(busy_sh), 0);
    rst = 1'b0;

    // Unit busy forced low: busy_err sets and sticks
    drive(4'd0, 1'b0, 1'b0);
    chk("berr.clear", 32'(busy_err), 0);
    force_low = 1'b1;
    drive(4'd1, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0);
    chk("berr.set", 32'(busy_err), 1);
    force_low = 1'b0;
    for (int i = 0; i < 8; i++) drive(4'd0, 1'b0, 1'b0);
    chk("berr.sticky", 32'(busy_err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
